adder_operand_loader: RTL

- Producer end of the adder-tree operand interface. Collects a serial stream of DATA_WIDTH-bit words over a valid/ready handshake and assembles them into the packed SIZE-lane vector consumed by the adder tree.
- Presents the full vector with a valid/ready handshake. The vector is held stable until it is taken.
- Sits between the upstream operand source (for example the partial-product generator) and the combinational reduction tree.

---
 rtl/adder_operand_loader.sv | 132 +++++++++++++
 1 files changed

// File: rtl/adder_operand_loader.sv
// Operand loader: packs a serial stream of DATA_WIDTH-bit words into a SIZE-lane vector for the adder tree.
// Optional early close on in_last is enabled by defining ADDER_LOADER_PARTIAL_EN.
module adder_operand_loader #(
    parameter int SIZE       = 4,
    parameter int DATA_WIDTH = 4,
    localparam int CNT_W     = $clog2(SIZE + 1)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DATA_WIDTH-1:0]        in_data,
    input  logic                         in_last,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [SIZE*DATA_WIDTH-1:0]   out_vector,
    output logic [CNT_W-1:0]             out_count
);

    typedef enum logic [0:0] {
        ST_FILL = 1'b0,
        ST_FULL = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(SIZE - 1);

    state_t                       r_state;
    logic [CNT_W-1:0]             r_cnt;
    logic [SIZE*DATA_WIDTH-1:0]   r_vector;
    logic                         r_out_valid;
    logic                         r_in_ready;

    state_t                       w_state;
    logic [CNT_W-1:0]             w_cnt;
    logic [SIZE*DATA_WIDTH-1:0]   w_vector;
    logic                         w_out_valid;
    logic                         w_in_ready;
    logic                         w_accept;
    logic                         w_close;

`ifdef ADDER_LOADER_PARTIAL_EN
    logic                         w_early_close;
    assign w_early_close = in_last;
`else
    logic                         w_unused_last;
    logic                         w_early_close;
    assign w_unused_last = in_last;
    assign w_early_close = 1'b0;
`endif

    assign w_accept = in_valid && r_in_ready;

    // Next-state and datapath update for the fill/hold handshake
    always_comb begin
        w_state     = r_state;
        w_cnt       = r_cnt;
        w_vector    = r_vector;
        w_out_valid = r_out_valid;
        w_in_ready  = r_in_ready;
        w_close     = 1'b0;
        case (r_state)
            ST_FILL: begin
                w_in_ready  = 1'b1;
                w_out_valid = 1'b0;
                if (w_accept) begin
                    for (int k = 0; k < SIZE; k++) begin
                        if (r_cnt == CNT_W'(k)) begin
                            w_vector[k*DATA_WIDTH +: DATA_WIDTH] = in_data;
                        end else begin
                            w_vector[k*DATA_WIDTH +: DATA_WIDTH] = r_vector[k*DATA_WIDTH +: DATA_WIDTH];
                        end
                    end
                    w_cnt   = r_cnt + CNT_W'(1);
                    w_close = (r_cnt == LAST_IDX) || w_early_close;
                    if (w_close) begin
                        w_state     = ST_FULL;
                        w_out_valid = 1'b1;
                        w_in_ready  = 1'b0;
                    end else begin
                        w_state     = ST_FILL;
                    end
                end else begin
                    w_state = ST_FILL;
                end
            end
            ST_FULL: begin
                // Vector and count stay frozen until the adder side takes them
                if (r_out_valid && out_ready) begin
                    w_state     = ST_FILL;
                    w_cnt       = {CNT_W{1'b0}};
                    w_vector    = {(SIZE*DATA_WIDTH){1'b0}};
                    w_out_valid = 1'b0;
                    w_in_ready  = 1'b1;
                end else begin
                    w_state     = ST_FULL;
                    w_out_valid = 1'b1;
                    w_in_ready  = 1'b0;
                end
            end
            default: begin
                w_state     = ST_FILL;
                w_cnt       = {CNT_W{1'b0}};
                w_vector    = {(SIZE*DATA_WIDTH){1'b0}};
                w_out_valid = 1'b0;
                w_in_ready  = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_FILL;
            r_cnt       <= {CNT_W{1'b0}};
            r_vector    <= {(SIZE*DATA_WIDTH){1'b0}};
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_cnt       <= w_cnt;
            r_vector    <= w_vector;
            r_out_valid <= w_out_valid;
            r_in_ready  <= w_in_ready;
        end
    end

    assign in_ready   = r_in_ready;
    assign out_valid  = r_out_valid;
    assign out_vector = r_vector;
    assign out_count  = r_cnt;

endmodule
